// File: rtl/cache_types.sv
// cache_types: shared cache constants and the line adapter state encoding
package cache_types;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS = 4;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BEAT, DONE} adapter_state_t;
endpackage

// File: rtl/cacheline_adapter_if.sv
// cacheline_adapter_if: cache dfp port (256-bit line, held request, one-cycle resp) plus 64-bit burst memory port; slave = adapter view, master = surrounding cache/memory view
interface cacheline_adapter_if;
  import cache_types::*;
  logic [31:0] dfp_addr;
  logic dfp_read;
  logic dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic dfp_resp;
  logic [31:0] bmem_addr;
  logic bmem_read;
  logic bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic bmem_ready;
  logic [BEAT_W-1:0] bmem_rdata;
  logic bmem_rvalid;
  modport slave (
    input dfp_addr, dfp_read, dfp_write, dfp_wdata, bmem_ready, bmem_rdata, bmem_rvalid,
    output dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata, bmem_ready, bmem_rdata, bmem_rvalid,
    input dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: splits 256-bit line writebacks into 64-bit beats and assembles read beats into fill lines; ports clk, rst (async high), bus (slave: dfp_* cache side, bmem_* burst memory side)
module cacheline_adapter #(
  parameter int BEATS = 4,
  parameter int BEAT_W = 64
) (
  input logic clk,
  input logic rst,
  cacheline_adapter_if.slave bus
);
  import cache_types::*;
  localparam int LW = BEATS * BEAT_W;
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  adapter_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:5] addr_q;
  logic [LW-1:0] line_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      line_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (bus.dfp_write || bus.dfp_read)) begin
        addr_q <= bus.dfp_addr[31:5];
        cnt <= '0;
      end
      if (state == IDLE && bus.dfp_write) line_q <= bus.dfp_wdata;
      if (state == RD_WAIT && bus.bmem_rvalid) begin
        line_q[cnt*BEAT_W +: BEAT_W] <= bus.bmem_rdata;
        cnt <= cnt + 1'b1;
      end
      if (state == WR_BEAT && bus.bmem_ready) cnt <= cnt + 1'b1;
    end
  // DONE never looks at the request: the cache still holds it during the resp cycle
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = bus.dfp_write ? WR_BEAT : bus.dfp_read ? RD_REQ : IDLE;
      RD_REQ:  state_n = bus.bmem_ready ? RD_WAIT : RD_REQ;
      RD_WAIT: state_n = (bus.bmem_rvalid && cnt == LAST) ? DONE : RD_WAIT;
      WR_BEAT: state_n = (bus.bmem_ready && cnt == LAST) ? DONE : WR_BEAT;
      default: state_n = IDLE;
    endcase
  end
  assign bus.bmem_addr = {addr_q, 5'b0};
  assign bus.bmem_read = state == RD_REQ;
  assign bus.bmem_write = state == WR_BEAT;
  assign bus.bmem_wdata = state == WR_BEAT ? line_q[cnt*BEAT_W +: BEAT_W] : '0;
  assign bus.dfp_resp = state == DONE;
  assign bus.dfp_rdata = state == DONE ? line_q : '0;
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: directed self-checking bench for cacheline_adapter
module tb_cacheline_adapter;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int a0;
  cacheline_adapter_if bus();
  cacheline_adapter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [63:0] rep(input logic [3:0] n);
    return {16{n}};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd_line(input string tag, input logic [31:0] a, input logic [3:0] b0);
    bus.dfp_addr = a;
    bus.dfp_read = 1'b1;
    bus.bmem_ready = 1'b1;
    tick;
    chk({tag, "_req"}, bus.bmem_read, 1'b1);
    chk({tag, "_addr"}, bus.bmem_addr, {a[31:5], 5'b0});
    tick;
    chk({tag, "_req_drop"}, bus.bmem_read, 1'b0);
    bus.bmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata = rep(4'(b0 + i));
      tick;
    end
    bus.bmem_rvalid = 1'b0;
    chk({tag, "_resp"}, bus.dfp_resp, 1'b1);
    chk({tag, "_line"}, bus.dfp_rdata, {rep(4'(b0 + 3)), rep(4'(b0 + 2)), rep(4'(b0 + 1)), rep(b0)});
  endtask
  always @(negedge clk) begin
    if (bus.bmem_read && bus.bmem_ready) n_acc++;
    assert (!(bus.bmem_read && bus.bmem_write)) else begin
      n_fail++;
      $error("FAIL bmem_rw_both: observed 1 expected 0");
    end
    assert (!(bus.dfp_read && bus.dfp_write)) else begin
      n_fail++;
      $error("FAIL dfp_rw_both: observed 1 expected 0");
    end
  end
  initial begin
    rst = 1'b1;
    bus.dfp_addr = '0;
    bus.dfp_read = 1'b0;
    bus.dfp_write = 1'b0;
    bus.dfp_wdata = '0;
    bus.bmem_ready = 1'b0;
    bus.bmem_rdata = '0;
    bus.bmem_rvalid = 1'b0;
    tick;
    tick;
    chk("rst_resp", bus.dfp_resp, 1'b0);
    chk("rst_read", bus.bmem_read, 1'b0);
    chk("rst_write", bus.bmem_write, 1'b0);
    chk("rst_rdata", bus.dfp_rdata, '0);
    chk("rst_wdata", bus.bmem_wdata, '0);
    chk("rst_addr", bus.bmem_addr, '0);
    rst = 1'b0;
    tick;
    // read fill, best case: resp at T+6 for one cycle
    bus.dfp_addr = 32'h1234_5678;
    bus.dfp_read = 1'b1;
    tick;
    chk("fill_req", bus.bmem_read, 1'b1);
    chk("fill_addr", bus.bmem_addr, 32'h1234_5660);
    bus.bmem_ready = 1'b1;
    tick;
    chk("fill_req_drop", bus.bmem_read, 1'b0);
    bus.bmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata = rep(4'(i + 1));
      tick;
      if (i < 3) chk("fill_resp_early", bus.dfp_resp, 1'b0);
    end
    chk("fill_resp", bus.dfp_resp, 1'b1);
    chk("fill_line", bus.dfp_rdata, {rep(4'h4), rep(4'h3), rep(4'h2), rep(4'h1)});
    chk("fill_addr_const", bus.bmem_addr, 32'h1234_5660);
    bus.bmem_rvalid = 1'b0;
    bus.dfp_read = 1'b0;
    tick;
    chk("fill_resp_one", bus.dfp_resp, 1'b0);
    // writeback, ready high throughout
    bus.dfp_addr = 32'hABCD_EF1F;
    bus.dfp_wdata = {rep(4'hD), rep(4'hC), rep(4'hB), rep(4'hA)};
    bus.dfp_write = 1'b1;
    bus.bmem_ready = 1'b1;
    tick;
    chk("wb_addr", bus.bmem_addr, 32'hABCD_EF00);
    for (int i = 0; i < 4; i++) begin
      chk("wb_valid", bus.bmem_write, 1'b1);
      chk("wb_beat", bus.bmem_wdata, rep(4'(4'hA + i)));
      chk("wb_resp_early", bus.dfp_resp, 1'b0);
      tick;
    end
    chk("wb_resp", bus.dfp_resp, 1'b1);
    chk("wb_write_drop", bus.bmem_write, 1'b0);
    bus.dfp_write = 1'b0;
    tick;
    chk("wb_resp_one", bus.dfp_resp, 1'b0);
    // writeback with ready low on T+2, T+3
    bus.dfp_wdata = {rep(4'h8), rep(4'h7), rep(4'h6), rep(4'h5)};
    bus.dfp_write = 1'b1;
    tick;
    chk("bp_beat0", bus.bmem_wdata, rep(4'h5));
    tick;
    chk("bp_beat1", bus.bmem_wdata, rep(4'h6));
    bus.bmem_ready = 1'b0;
    tick;
    chk("bp_hold1", bus.bmem_wdata, rep(4'h6));
    tick;
    chk("bp_hold2", bus.bmem_wdata, rep(4'h6));
    chk("bp_hold_valid", bus.bmem_write, 1'b1);
    bus.bmem_ready = 1'b1;
    tick;
    chk("bp_beat2", bus.bmem_wdata, rep(4'h7));
    tick;
    chk("bp_beat3", bus.bmem_wdata, rep(4'h8));
    chk("bp_resp_early", bus.dfp_resp, 1'b0);
    tick;
    chk("bp_resp", bus.dfp_resp, 1'b1);
    bus.dfp_write = 1'b0;
    bus.bmem_ready = 1'b0;
    tick;
    // stray rvalid while idle, then gapped read with a ready stall
    bus.bmem_rvalid = 1'b1;
    bus.bmem_rdata = rep(4'hF);
    tick;
    chk("stray_read", bus.bmem_read, 1'b0);
    chk("stray_resp", bus.dfp_resp, 1'b0);
    bus.bmem_rvalid = 1'b0;
    bus.dfp_addr = 32'h0000_0040;
    bus.dfp_read = 1'b1;
    tick;
    chk("gap_req", bus.bmem_read, 1'b1);
    tick;
    chk("gap_req_hold", bus.bmem_read, 1'b1);
    bus.bmem_ready = 1'b1;
    tick;
    chk("gap_req_drop", bus.bmem_read, 1'b0);
    bus.bmem_ready = 1'b0;
    a0 = 9;
    for (int k = 1; k <= 9; k++) begin
      bus.bmem_rvalid = (k == 2 || k == 4 || k == 5 || k == 9);
      bus.bmem_rdata = bus.bmem_rvalid ? rep(4'(a0)) : rep(4'hE);
      if (bus.bmem_rvalid) a0++;
      tick;
      if (k < 9) chk("gap_resp_early", bus.dfp_resp, 1'b0);
    end
    bus.bmem_rvalid = 1'b0;
    chk("gap_resp", bus.dfp_resp, 1'b1);
    chk("gap_line", bus.dfp_rdata, {rep(4'hC), rep(4'hB), rep(4'hA), rep(4'h9)});
    bus.dfp_read = 1'b0;
    tick;
    // async reset after two read beats
    bus.dfp_addr = 32'h8000_0020;
    bus.dfp_read = 1'b1;
    bus.bmem_ready = 1'b1;
    tick;
    tick;
    bus.bmem_ready = 1'b0;
    bus.bmem_rvalid = 1'b1;
    bus.bmem_rdata = rep(4'h1);
    tick;
    bus.bmem_rdata = rep(4'h2);
    tick;
    chk("pre_rst_addr", bus.bmem_addr, 32'h8000_0020);
    bus.bmem_rdata = rep(4'h3);
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", bus.bmem_addr, '0);
    chk("arst_read", bus.bmem_read, 1'b0);
    chk("arst_resp", bus.dfp_resp, 1'b0);
    chk("arst_rdata", bus.dfp_rdata, '0);
    tick;
    rst = 1'b0;
    bus.dfp_read = 1'b0;
    tick;
    chk("post_rst_idle", bus.bmem_read, 1'b0);
    bus.bmem_rvalid = 1'b0;
    rd_line("post_rst", 32'h8000_0020, 4'h5);
    bus.dfp_read = 1'b0;
    tick;
    chk("post_rst_resp_one", bus.dfp_resp, 1'b0);
    // back-to-back reads with request held through the resp cycle
    a0 = n_acc;
    rd_line("b2b1", 32'h0000_1000, 4'h2);
    tick;
    chk("b2b_no_dup0", bus.bmem_read, 1'b0);
    bus.dfp_read = 1'b0;
    tick;
    chk("b2b_no_dup1", bus.bmem_read, 1'b0);
    rd_line("b2b2", 32'h0000_2000, 4'h6);
    bus.dfp_read = 1'b0;
    tick;
    chk("b2b_accepts", n_acc - a0, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
